// File: rtl/io_alu_pkg.sv
// Shared definitions for the CPU IO port responder that fronts the shared ALU.
// Holds the io_control field positions, the io_status bit indices, the ALU
// select and mode codes, the responder state encoding and a one-hot helper.
package io_alu_pkg;

  // io_control field positions
  localparam int IO_CTRL_STA      = 0;
  localparam int IO_CTRL_MODEL_LO = 1;
  localparam int IO_CTRL_MODEL_HI = 2;
  localparam int IO_CTRL_ALU_LO   = 3;
  localparam int IO_CTRL_ALU_HI   = 6;

  // io_status bit indices
  localparam int IO_STAT_DONE    = 0;
  localparam int IO_STAT_BUSY    = 1;
  localparam int IO_STAT_TIMEOUT = 2;
  localparam int IO_STAT_ILLEGAL = 3;

  // ALU select codes (one-hot)
  localparam logic [3:0] ALU_MULTIPLY = 4'b1000;
  localparam logic [3:0] ALU_DIVISION = 4'b0100;
  localparam logic [3:0] ALU_SQRTPOWS = 4'b0010;
  localparam logic [3:0] ALU_UNKNOWN  = 4'b0001;

  // ALU mode codes, passed through unchanged to the ALU
  localparam logic [1:0] MODE_0 = 2'b00;
  localparam logic [1:0] MODE_1 = 2'b01;
  localparam logic [1:0] MODE_2 = 2'b10;
  localparam logic [1:0] MODE_3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } io_alu_state_e;

  // True when exactly one bit of a 4-bit select is set.
  function automatic logic is_one_hot4(input logic [3:0] sel);
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < 4; i++) begin
      ones = ones + {2'b00, sel[i]};
    end
    return (ones == 3'd1);
  endfunction

endpackage

// File: rtl/io_alu_watchdog.sv
// Cycle watchdog for the BUSY window.
// Ports: clk/rst (async active-high), clear restarts the count at zero,
// enable advances it once per cycle, expired flags that the current enabled
// cycle is the TIMEOUT_CYCLES-th one since the last clear.
module io_alu_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count_r;

  // Expired while the count shows TIMEOUT_CYCLES-1 completed cycles, so the
  // owner leaves BUSY after exactly TIMEOUT_CYCLES cycles.
  assign expired = (count_r >= 16'(TIMEOUT_CYCLES - 1));

  // Cycle counter: clear has priority, saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 16'd0;
    end else if (clear) begin
      count_r <= 16'd0;
    end else if (enable && (count_r != 16'hFFFF)) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/io_alu_responder.sv
// Peripheral-side responder between the CPU IO registers and the shared ALU.
// Ports: io_control/io_dataoutA/io_dataoutB from the CPU; io_status and
// io_datainA/B back to it; alu_start/alu_type/mode_type/X_IN/Y_IN to the ALU;
// FOUT/POUT/alu_is_done from the ALU. All outputs are registered.
module io_alu_responder
  import io_alu_pkg::*;
#(
  parameter int GENERAL_REG_WIDTH = 16,
  parameter int MAX_SQRT_WIDTH    = 13,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [GENERAL_REG_WIDTH-1:0] io_control,
  input  logic [GENERAL_REG_WIDTH-1:0] io_dataoutA,
  input  logic [GENERAL_REG_WIDTH-1:0] io_dataoutB,
  output logic [GENERAL_REG_WIDTH-1:0] io_status,
  output logic [GENERAL_REG_WIDTH-1:0] io_datainA,
  output logic [GENERAL_REG_WIDTH-1:0] io_datainB,
  output logic                         alu_start,
  output logic [3:0]                   alu_type,
  output logic [1:0]                   mode_type,
  output logic [MAX_SQRT_WIDTH-1:0]    X_IN,
  output logic [MAX_SQRT_WIDTH-1:0]    Y_IN,
  input  logic [MAX_SQRT_WIDTH-1:0]    FOUT,
  input  logic [MAX_SQRT_WIDTH-1:0]    POUT,
  input  logic                         alu_is_done
);

  localparam int PAD_W = GENERAL_REG_WIDTH - MAX_SQRT_WIDTH;

  io_alu_state_e             state_r, state_s;
  logic                      start_q_r, armed_r;
  logic                      alu_start_r, alu_start_s;
  logic [3:0]                alu_type_r, alu_type_s;
  logic [1:0]                mode_r, mode_s;
  logic [MAX_SQRT_WIDTH-1:0] x_r, x_s, y_r, y_s, fout_r, fout_s, pout_r, pout_s;
  logic                      done_r, done_s, busy_r, busy_s;
  logic                      timeout_r, timeout_s, illegal_r, illegal_s;
  logic                      start_s, launch_s, wd_clear_s, wd_expired_s;

  assign start_s = io_control[IO_CTRL_STA];
  // armed_r is only set once start has been seen low after reset, so a start
  // level held across reset release cannot masquerade as a new request.
  assign launch_s = start_s & ~start_q_r & armed_r;

  io_alu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear_s),
    .enable  (state_r == ST_BUSY),
    .expired (wd_expired_s)
  );

  // Next-state and next-register logic for the launch/busy/done handshake.
  always_comb begin
    state_s     = state_r;
    alu_start_s = alu_start_r;
    alu_type_s  = alu_type_r;
    mode_s      = mode_r;
    x_s         = x_r;
    y_s         = y_r;
    fout_s      = fout_r;
    pout_s      = pout_r;
    done_s      = done_r;
    busy_s      = busy_r;
    timeout_s   = timeout_r;
    illegal_s   = illegal_r;
    wd_clear_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          alu_type_s = io_control[IO_CTRL_ALU_HI:IO_CTRL_ALU_LO];
          mode_s     = io_control[IO_CTRL_MODEL_HI:IO_CTRL_MODEL_LO];
          x_s        = io_dataoutA[MAX_SQRT_WIDTH-1:0];
          y_s        = io_dataoutB[MAX_SQRT_WIDTH-1:0];
          if (is_one_hot4(io_control[IO_CTRL_ALU_HI:IO_CTRL_ALU_LO])) begin
            state_s     = ST_BUSY;
            alu_start_s = 1'b1;
            busy_s      = 1'b1;
            wd_clear_s  = 1'b1;
          end else begin
            state_s   = ST_DONE;
            illegal_s = 1'b1;
            done_s    = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Completion outranks both a CPU abort and the watchdog.
        if (alu_is_done) begin
          fout_s      = FOUT;
          pout_s      = POUT;
          alu_start_s = 1'b0;
          busy_s      = 1'b0;
          done_s      = 1'b1;
          state_s     = ST_DONE;
        end else if (!start_s) begin
          alu_start_s = 1'b0;
          busy_s      = 1'b0;
          state_s     = ST_IDLE;
        end else if (wd_expired_s) begin
          alu_start_s = 1'b0;
          busy_s      = 1'b0;
          timeout_s   = 1'b1;
          done_s      = 1'b1;
          state_s     = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (!start_s) begin
          done_s    = 1'b0;
          timeout_s = 1'b0;
          illegal_s = 1'b0;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        alu_start_s = 1'b0;
        done_s      = 1'b0;
        busy_s      = 1'b0;
        timeout_s   = 1'b0;
        illegal_s   = 1'b0;
      end
    endcase
  end

  // State, latched operands, captured results and sticky status bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      start_q_r   <= 1'b0;
      armed_r     <= 1'b0;
      alu_start_r <= 1'b0;
      alu_type_r  <= 4'd0;
      mode_r      <= 2'd0;
      x_r         <= '0;
      y_r         <= '0;
      fout_r      <= '0;
      pout_r      <= '0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      timeout_r   <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      start_q_r   <= start_s;
      armed_r     <= armed_r | ~start_s;
      alu_start_r <= alu_start_s;
      alu_type_r  <= alu_type_s;
      mode_r      <= mode_s;
      x_r         <= x_s;
      y_r         <= y_s;
      fout_r      <= fout_s;
      pout_r      <= pout_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
      timeout_r   <= timeout_s;
      illegal_r   <= illegal_s;
    end
  end

  assign alu_start  = alu_start_r;
  assign alu_type   = alu_type_r;
  assign mode_type  = mode_r;
  assign X_IN       = x_r;
  assign Y_IN       = y_r;
  assign io_datainA = {{PAD_W{1'b0}}, fout_r};
  assign io_datainB = {{PAD_W{1'b0}}, pout_r};
  assign io_status  = {{(GENERAL_REG_WIDTH-4){1'b0}}, illegal_r, timeout_r, busy_r, done_r};

endmodule

// File: tb/tb_io_alu_responder.sv
// Directed bench for io_alu_responder: one instance with the default watchdog
// for the functional sequence, one with an 8-cycle watchdog and a silent ALU.
module tb_io_alu_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] io_control = 16'h0000, io_dataoutA = 16'h0000, io_dataoutB = 16'h0000;
  logic [15:0] io_status, io_datainA, io_datainB;
  logic        alu_start;
  logic [3:0]  alu_type;
  logic [1:0]  mode_type;
  logic [12:0] x_in, y_in;
  logic [12:0] fout = 13'd0, pout = 13'd0;
  logic        alu_is_done = 1'b0;

  logic [15:0] wd_control = 16'h0000;
  logic [15:0] wd_status, wd_datainA, wd_datainB;
  logic        wd_alu_start;
  logic [3:0]  wd_alu_type;
  logic [1:0]  wd_mode_type;
  logic [12:0] wd_x_in, wd_y_in;

  int vectors = 0;
  int miscompares = 0;
  int high_cycles;

  always #5 clk = ~clk;

  io_alu_responder dut (
    .clk(clk), .rst(rst),
    .io_control(io_control), .io_dataoutA(io_dataoutA), .io_dataoutB(io_dataoutB),
    .io_status(io_status), .io_datainA(io_datainA), .io_datainB(io_datainB),
    .alu_start(alu_start), .alu_type(alu_type), .mode_type(mode_type),
    .X_IN(x_in), .Y_IN(y_in), .FOUT(fout), .POUT(pout), .alu_is_done(alu_is_done)
  );

  io_alu_responder #(.TIMEOUT_CYCLES(8)) dut_wd (
    .clk(clk), .rst(rst),
    .io_control(wd_control), .io_dataoutA(16'h0005), .io_dataoutB(16'h0007),
    .io_status(wd_status), .io_datainA(wd_datainA), .io_datainB(wd_datainB),
    .alu_start(wd_alu_start), .alu_type(wd_alu_type), .mode_type(wd_mode_type),
    .X_IN(wd_x_in), .Y_IN(wd_y_in), .FOUT(13'h1555), .POUT(13'h0AAA), .alu_is_done(1'b0)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_status", io_status, 16'h0000);
    chk("rst_datainA", io_datainA, 16'h0000);
    chk("rst_alu_start", {15'd0, alu_start}, 16'h0000);
    rst = 1'b0;
    tick();

    // Multiply 240 x 106
    io_control = 16'h0043; io_dataoutA = 16'd240; io_dataoutB = 16'd106;
    tick();
    chk("mul_alu_start", {15'd0, alu_start}, 16'h0001);
    chk("mul_alu_type", {12'd0, alu_type}, 16'h0008);
    chk("mul_mode", {14'd0, mode_type}, 16'h0001);
    chk("mul_y_in", {3'd0, y_in}, 16'd106);
    chk("mul_busy", io_status, 16'h0002);
    io_dataoutA = 16'h1FFF;
    for (int i = 0; i < 18; i++) tick();
    chk("iso_x_in", {3'd0, x_in}, 16'd240);
    chk("mul_still_busy", io_status, 16'h0002);
    alu_is_done = 1'b1; fout = 13'h0ABC; pout = 13'h0123;
    tick();
    alu_is_done = 1'b0; fout = 13'd0; pout = 13'd0;
    chk("mul_done_status", io_status, 16'h0001);
    chk("mul_datainA", io_datainA, 16'h0ABC);
    chk("mul_datainB", io_datainB, 16'h0123);
    chk("mul_start_low", {15'd0, alu_start}, 16'h0000);
    io_dataoutA = 16'h0777;
    tick();
    chk("mul_hold", io_status, 16'h0001);
    chk("mul_hold_x", {3'd0, x_in}, 16'd240);
    io_control = 16'h0000;
    tick();
    chk("mul_clear", io_status, 16'h0000);
    chk("mul_keep_A", io_datainA, 16'h0ABC);

    // Illegal alu_type 0000
    io_control = 16'h0001;
    tick();
    chk("ill_status", io_status, 16'h0009);
    chk("ill_no_start", {15'd0, alu_start}, 16'h0000);
    tick();
    chk("ill_hold", io_status, 16'h0009);
    chk("ill_keep_A", io_datainA, 16'h0ABC);
    io_control = 16'h0000;
    tick();
    chk("ill_clear", io_status, 16'h0000);

    // Abort at BUSY cycle 5
    io_control = 16'h0023; io_dataoutA = 16'd9; io_dataoutB = 16'd3;
    tick();
    chk("abt_type", {12'd0, alu_type}, 16'h0004);
    for (int i = 0; i < 4; i++) tick();
    io_control = 16'h0000;
    tick();
    chk("abt_start_low", {15'd0, alu_start}, 16'h0000);
    chk("abt_status", io_status, 16'h0000);
    tick();
    chk("abt_idle", io_status, 16'h0000);
    chk("abt_keep_A", io_datainA, 16'h0ABC);

    // Abort colliding with done: capture wins
    io_control = 16'h0013;
    tick(); tick(); tick();
    io_control = 16'h0000; alu_is_done = 1'b1; fout = 13'h0111; pout = 13'h0222;
    tick();
    alu_is_done = 1'b0;
    chk("col_status", io_status, 16'h0001);
    chk("col_datainA", io_datainA, 16'h0111);
    chk("col_datainB", io_datainB, 16'h0222);
    tick();
    chk("col_idle", io_status, 16'h0000);

    // Reset mid-BUSY, then no relaunch while start stays high
    io_control = 16'h000B; io_dataoutA = 16'd33;
    tick();
    chk("rmb_start", {15'd0, alu_start}, 16'h0001);
    #2 rst = 1'b1;
    #1;
    chk("rmb_alu_start", {15'd0, alu_start}, 16'h0000);
    chk("rmb_status", io_status, 16'h0000);
    chk("rmb_datainA", io_datainA, 16'h0000);
    chk("rmb_x_in", {3'd0, x_in}, 16'h0000);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rmb_no_relaunch", {15'd0, alu_start}, 16'h0000);
    chk("rmb_no_status", io_status, 16'h0000);
    io_control = 16'h0000;
    tick();
    io_control = 16'h000B;
    tick();
    chk("rmb_relaunch", {15'd0, alu_start}, 16'h0001);
    chk("rmb_relaunch_st", io_status, 16'h0002);
    chk("rmb_relaunch_x", {3'd0, x_in}, 16'd33);
    io_control = 16'h0000;
    tick();
    chk("rmb_abort", {15'd0, alu_start}, 16'h0000);

    // Watchdog: 8-cycle limit, ALU never finishes
    wd_control = 16'h0043;
    tick();
    high_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (wd_alu_start) high_cycles++;
      tick();
    end
    chk("wd_high_cycles", 16'(high_cycles), 16'd8);
    chk("wd_status", wd_status, 16'h0005);
    chk("wd_keep_A", wd_datainA, 16'h0000);
    chk("wd_keep_B", wd_datainB, 16'h0000);
    wd_control = 16'h0000;
    tick();
    chk("wd_clear", wd_status, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
